pixel_writer: RTL and testbench

- Consumer end of the geometry pixel-coordinate interface: accepts X/Y pixels plus colour from a line/shape generator and converts them to linear bitmap addresses.
- Clips off-screen pixels, buffers accepted writes in a small FIFO, and issues single-pixel write requests to the memory arbiter with a req/ack handshake.
- Drives the generator's draw_busy stall input as its flow control.

---
 rtl/pixel_writer.sv | 133 +++++++++++++
 tb/tb_pixel_writer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Pixel-coordinate consumer: clips off-screen pixels, converts X/Y to linear
// bitmap addresses and queues single-pixel write requests to the memory arbiter.
module pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 20,
    parameter int COLOR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_data_rdy,
    input  logic signed [11:0]    X_coord,
    input  logic signed [11:0]    Y_coord,
    input  logic [COLOR_BITS-1:0] color,
    input  logic [ADDR_BITS-1:0]  dest_base,
    input  logic [11:0]           dest_width,
    input  logic [11:0]           dest_height,
    output logic                  draw_busy,
    output logic                  wr_req,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [COLOR_BITS-1:0] wr_data,
    input  logic                  wr_ack,
    output logic                  idle,
    output logic [15:0]           clip_count
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int OCC_BITS = PTR_BITS + 2;

    logic                  s1_valid;
    logic [11:0]           s1_x;
    logic [11:0]           s1_y;
    logic [11:0]           s1_width;
    logic [ADDR_BITS-1:0]  s1_base;
    logic [COLOR_BITS-1:0] s1_color;

    logic                  s2_valid;
    logic [ADDR_BITS-1:0]  s2_addr;
    logic [COLOR_BITS-1:0] s2_color;

    logic [ADDR_BITS-1:0]  fifo_addr [FIFO_DEPTH];
    logic [COLOR_BITS-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CNT_BITS-1:0]   count;

    logic                  accept;
    logic                  on_screen;
    logic                  push;
    logic                  pop;
    logic [OCC_BITS-1:0]   occupancy;
    logic [ADDR_BITS-1:0]  addr_next;

    // Everything in flight counts, so a stall raised now leaves room for the
    // pixels already in the clip and address stages.
    assign occupancy = OCC_BITS'(count) + OCC_BITS'(s1_valid) + OCC_BITS'(s2_valid);
    assign draw_busy = reset | (occupancy >= OCC_BITS'(FIFO_DEPTH));
    assign accept    = pixel_data_rdy & ~draw_busy;
    assign idle      = (occupancy == '0);

    assign on_screen = ~X_coord[11] & ~Y_coord[11]
                     & ($unsigned(X_coord) < dest_width)
                     & ($unsigned(Y_coord) < dest_height);

    // Arithmetic at ADDR_BITS width is the required modulo-2^ADDR_BITS wrap.
    assign addr_next = s1_base
                     + (ADDR_BITS'(s1_y) * ADDR_BITS'(s1_width))
                     + ADDR_BITS'(s1_x);

    assign push = s2_valid;
    assign pop  = wr_req & wr_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_width   <= '0;
            s1_base    <= '0;
            s1_color   <= '0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s2_color   <= '0;
            clip_count <= '0;
        end else begin
            s1_valid <= accept & on_screen;
            if (accept) begin
                s1_x     <= $unsigned(X_coord);
                s1_y     <= $unsigned(Y_coord);
                s1_width <= dest_width;
                s1_base  <= dest_base;
                s1_color <= color;
            end
            if (accept && !on_screen && clip_count != 16'hFFFF) begin
                clip_count <= clip_count + 16'd1;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr  <= addr_next;
                s2_color <= s1_color;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
        end
    end

    // Storage is not reset; the outputs are gated by wr_req instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= s2_addr;
            fifo_data[wr_ptr] <= s2_color;
        end
    end

    assign wr_req  = (count != '0);
    assign wr_addr = wr_req ? fifo_addr[rd_ptr] : '0;
    assign wr_data = wr_req ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed scenarios plus randomized
// streaming, compared every cycle against a timestamped queue model.
module tb_pixel_writer;

    localparam int DEPTH = 4;
    localparam int AB    = 20;
    localparam int CB    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pixel_data_rdy = 1'b0;
    logic signed [11:0] X_coord = '0;
    logic signed [11:0] Y_coord = '0;
    logic [CB-1:0]     color = '0;
    logic [AB-1:0]     dest_base = '0;
    logic [11:0]       dest_width = '0;
    logic [11:0]       dest_height = '0;
    logic              wr_ack = 1'b0;
    logic              draw_busy;
    logic              wr_req;
    logic [AB-1:0]     wr_addr;
    logic [CB-1:0]     wr_data;
    logic              idle;
    logic [15:0]       clip_count;

    pixel_writer #(.FIFO_DEPTH(DEPTH), .ADDR_BITS(AB), .COLOR_BITS(CB)) dut (
        .clk(clk), .reset(reset), .pixel_data_rdy(pixel_data_rdy),
        .X_coord(X_coord), .Y_coord(Y_coord), .color(color),
        .dest_base(dest_base), .dest_width(dest_width), .dest_height(dest_height),
        .draw_busy(draw_busy), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .idle(idle), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(string name, longint actual, longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic timeout_fail(string name);
        checks++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference model: pixels wait in pipe_q until their due edge, then sit in fifo_q.
    typedef struct {
        longint addr;
        longint data;
        int     due;
    } item_t;

    item_t pipe_q[$];
    item_t fifo_q[$];
    int    cyc = 0;
    int    m_clip = 0;
    bit    m_busy;

    function automatic int m_occ();
        return pipe_q.size() + fifo_q.size();
    endfunction

    function automatic void model_accept();
        int x, y, w, h;
        item_t it;
        x = $signed(X_coord);
        y = $signed(Y_coord);
        w = int'(dest_width);
        h = int'(dest_height);
        if (x < 0 || y < 0 || x >= w || y >= h) begin
            if (m_clip < 65535) m_clip++;
        end else begin
            it.addr = (longint'(dest_base) + longint'(y) * w + x) & ((longint'(1) << AB) - 1);
            it.data = longint'(color);
            it.due  = cyc + 2;
            pipe_q.push_back(it);
        end
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = (m_occ() >= DEPTH);
            if (fifo_q.size() > 0 && wr_ack) fifo_q.delete(0);
            while (pipe_q.size() > 0 && pipe_q[0].due == cyc) fifo_q.push_back(pipe_q.pop_front());
            if (pixel_data_rdy && !m_busy) model_accept();
            cyc++;
        end
    end

    // Per-cycle compare plus a log of writes the DUT actually hands over.
    longint log_q[$];
    int     log_t[$];
    int     tb_cyc = 0;
    bit     mon_busy_en = 1'b0;
    bit     busy_seen = 1'b0;

    always @(posedge clk) tb_cyc++;

    always @(negedge clk) begin
        longint e_addr, e_data;
        e_addr = (fifo_q.size() > 0) ? fifo_q[0].addr : 0;
        e_data = (fifo_q.size() > 0) ? fifo_q[0].data : 0;
        check("wr_req", longint'(wr_req), longint'(fifo_q.size() > 0));
        check("wr_addr", longint'(wr_addr), e_addr);
        check("wr_data", longint'(wr_data), e_data);
        check("draw_busy", longint'(draw_busy), longint'(reset || m_occ() >= DEPTH));
        check("idle", longint'(idle), longint'(m_occ() == 0));
        check("clip_count", longint'(clip_count), longint'(m_clip));
        if (!reset && wr_req && wr_ack) begin
            log_q.push_back(longint'(wr_addr));
            log_t.push_back(tb_cyc);
        end
        if (mon_busy_en && draw_busy) busy_seen = 1'b1;
    end

    task automatic set_cfg(int base, int w, int h);
        dest_base   = AB'(base);
        dest_width  = 12'(w);
        dest_height = 12'(h);
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the pixel until an edge where draw_busy was low; returns 1ns after that edge.
    task automatic send_pixel(int x, int y, int c);
        bit b;
        int n;
        X_coord = 12'(x);
        Y_coord = 12'(y);
        color   = CB'(c);
        pixel_data_rdy = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            b = draw_busy;
            @(posedge clk);
            #1;
            if (!b) break;
            n++;
            if (n > 200) begin
                timeout_fail("send_pixel");
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        pixel_data_rdy = 1'b0;
        pipe_q.delete();
        fifo_q.delete();
        m_clip = 0;
        #1;
        check("rst_wr_req", longint'(wr_req), 0);
        check("rst_idle", longint'(idle), 1);
        check("rst_clip", longint'(clip_count), 0);
        check("rst_busy", longint'(draw_busy), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic single_pixel_test(string tag);
        log_q.delete();
        wr_ack = 1'b1;
        set_cfg('h01000, 640, 480);
        send_pixel(10, 5, 'h3C);
        pixel_data_rdy = 1'b0;
        check({tag, "_lat0"}, longint'(wr_req), 0);
        wait_cycles(1);
        check({tag, "_lat1"}, longint'(wr_req), 0);
        wait_cycles(1);
        check({tag, "_lat2_req"}, longint'(wr_req), 1);
        check({tag, "_addr"}, longint'(wr_addr), 'h01C8A);
        check({tag, "_data"}, longint'(wr_data), 'h3C);
        wait_cycles(1);
        check({tag, "_popped"}, longint'(wr_req), 0);
        check({tag, "_idle"}, longint'(idle), 1);
        check({tag, "_writes"}, longint'(log_q.size()), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        int xr, yr;

        set_cfg('h01000, 640, 480);
        wr_ack = 1'b1;
        wait_cycles(3);
        check("reset_wr_req", longint'(wr_req), 0);
        check("reset_wr_addr", longint'(wr_addr), 0);
        check("reset_wr_data", longint'(wr_data), 0);
        check("reset_clip", longint'(clip_count), 0);
        check("reset_idle", longint'(idle), 1);
        check("reset_busy", longint'(draw_busy), 1);
        reset = 1'b0;
        #1;
        check("release_busy", longint'(draw_busy), 0);
        wait_cycles(1);

        single_pixel_test("single");

        // Clipping at each edge of a 640x480 bitmap.
        log_q.delete();
        send_pixel(-1, 0, 1);
        send_pixel(640, 0, 2);
        send_pixel(0, 480, 3);
        send_pixel(639, 479, 4);
        pixel_data_rdy = 1'b0;
        wait_cycles(5);
        check("clip_count3", longint'(clip_count), 3);
        check("clip_writes", longint'(log_q.size()), 1);
        if (log_q.size() > 0) check("clip_addr", log_q[0], 'h4BFFF);

        // Backpressure: no acks while a row of 8 pixels streams in.
        log_q.delete();
        wr_ack = 1'b0;
        fork
            begin
                for (int x = 0; x < 8; x++) send_pixel(x, 0, x + 1);
                pixel_data_rdy = 1'b0;
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                check("bp_busy", longint'(draw_busy), 1);
                check("bp_head", longint'(wr_addr), 'h01000);
                check("bp_req", longint'(wr_req), 1);
                wr_ack = 1'b1;
            end
        join
        wait_cycles(10);
        check("bp_writes", longint'(log_q.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) check("bp_order", log_q[i], 'h01000 + i);
        end

        // Address wrap modulo 2^20.
        log_q.delete();
        set_cfg('hFFFFF, 640, 480);
        send_pixel(1, 0, 'h11);
        pixel_data_rdy = 1'b0;
        set_cfg('hFFF00, 256, 480);
        send_pixel(0, 1, 'h22);
        pixel_data_rdy = 1'b0;
        wait_cycles(5);
        check("wrap_writes", longint'(log_q.size()), 2);
        if (log_q.size() > 1) begin
            check("wrap_addr0", log_q[0], 0);
            check("wrap_addr1", log_q[1], 0);
        end

        // Continuous stream with ack every cycle: no stalls, one write per cycle.
        log_q.delete();
        log_t.delete();
        set_cfg('h02000, 640, 480);
        wr_ack = 1'b1;
        busy_seen = 1'b0;
        mon_busy_en = 1'b1;
        for (int i = 0; i < 20; i++) send_pixel(i, 2, i);
        pixel_data_rdy = 1'b0;
        wait_cycles(5);
        mon_busy_en = 1'b0;
        check("stream_no_busy", longint'(busy_seen), 0);
        check("stream_writes", longint'(log_q.size()), 20);
        if (log_q.size() == 20) begin
            check("stream_last_addr", log_q[19], 'h02000 + 2 * 640 + 19);
            check("stream_rate", longint'(log_t[19] - log_t[0]), 19);
        end

        // Reset with three queued, unacknowledged writes.
        set_cfg('h01000, 640, 480);
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) send_pixel(100 + i, 7, i);
        pixel_data_rdy = 1'b0;
        wait_cycles(4);
        check("pre_rst_req", longint'(wr_req), 1);
        check("pre_rst_idle", longint'(idle), 0);
        do_reset();
        wait_cycles(1);
        single_pixel_test("post_rst");

        // Randomized streaming against the model.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            b = draw_busy;
            @(posedge clk);
            #1;
            if (!pixel_data_rdy || !b) begin
                pixel_data_rdy = ($urandom_range(0, 3) != 0);
                xr = int'($urandom_range(0, 50)) - 5;
                yr = int'($urandom_range(0, 40)) - 5;
                X_coord = 12'(xr);
                Y_coord = 12'(yr);
                color = CB'($urandom);
                if ($urandom_range(0, 7) == 0)
                    set_cfg(int'($urandom_range(0, (1 << AB) - 1)),
                            int'($urandom_range(0, 40)), int'($urandom_range(0, 30)));
            end
            wr_ack = ($urandom_range(0, 2) != 0);
        end
        pixel_data_rdy = 1'b0;
        wr_ack = 1'b1;
        wait_cycles(10);
        check("rand_drained_idle", longint'(idle), 1);
        check("rand_drained_req", longint'(wr_req), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
